// File: rtl/i2s_receiver_if.sv
// I2S receiver bus: serial word-select/data in, recovered stereo samples and status out.
interface i2s_receiver_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    i_word_select;
  logic                    i_sound_bit_in;
  logic [SAMPLE_WIDTH-1:0] o_left_sample;
  logic [SAMPLE_WIDTH-1:0] o_right_sample;
  logic                    o_sample_valid;
  logic                    o_frame_error;
  logic                    o_locked;

  modport master (
    output i_word_select,
    output i_sound_bit_in,
    input  o_left_sample,
    input  o_right_sample,
    input  o_sample_valid,
    input  o_frame_error,
    input  o_locked
  );

  modport slave (
    input  i_word_select,
    input  i_sound_bit_in,
    output o_left_sample,
    output o_right_sample,
    output o_sample_valid,
    output o_frame_error,
    output o_locked
  );
endinterface

// File: rtl/i2s_receiver.sv
// I2S receiver: aligns to word_select transitions and captures the first SAMPLE_WIDTH
// bits of each channel word, publishing a left/right pair once the right word is complete.
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic          i_serial_clk,
  input  logic          i_reset,
  i2s_receiver_if.slave i2s
);
  localparam int            CW     = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(SAMPLE_WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(SAMPLE_WIDTH - 1);

  typedef enum logic [1:0] {
    S_HUNT  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_ws_prev;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_next;
  logic [SAMPLE_WIDTH-1:0] r_shift;
  logic [SAMPLE_WIDTH-1:0] w_shift_next;
  logic [SAMPLE_WIDTH-1:0] r_left_hold;
  logic [SAMPLE_WIDTH-1:0] w_left_hold_next;
  logic [SAMPLE_WIDTH-1:0] r_left_sample;
  logic [SAMPLE_WIDTH-1:0] w_left_sample_next;
  logic [SAMPLE_WIDTH-1:0] r_right_sample;
  logic [SAMPLE_WIDTH-1:0] w_right_sample_next;
  logic                    r_sample_valid;
  logic                    w_sample_valid_next;
  logic                    r_frame_error;
  logic                    w_frame_error_next;
  logic                    r_locked;

  logic                    w_trans;
  logic                    w_fall;
  logic                    w_rise;
  logic                    w_bit_taken;
  logic                    w_word_done;
  logic                    w_word_full;
  logic [SAMPLE_WIDTH-1:0] w_shift_in;

  assign w_trans     = i2s.i_word_select ^ r_ws_prev;
  assign w_fall      = w_trans & ~i2s.i_word_select;
  assign w_rise      = w_trans & i2s.i_word_select;
  assign w_bit_taken = (r_cnt != C_FULL);
  // The bit on this edge is the SAMPLE_WIDTH-th of the word; a saturated counter already has them all.
  assign w_word_done = (r_cnt == C_LAST);
  assign w_word_full = w_word_done | ~w_bit_taken;
  assign w_shift_in  = {r_shift[SAMPLE_WIDTH-2:0], i2s.i_sound_bit_in};

  // State, datapath and registered outputs
  always_ff @(posedge i_serial_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_HUNT;
      r_ws_prev      <= 1'b0;
      r_cnt          <= {CW{1'b0}};
      r_shift        <= {SAMPLE_WIDTH{1'b0}};
      r_left_hold    <= {SAMPLE_WIDTH{1'b0}};
      r_left_sample  <= {SAMPLE_WIDTH{1'b0}};
      r_right_sample <= {SAMPLE_WIDTH{1'b0}};
      r_sample_valid <= 1'b0;
      r_frame_error  <= 1'b0;
      r_locked       <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_ws_prev      <= i2s.i_word_select;
      r_cnt          <= w_cnt_next;
      r_shift        <= w_shift_next;
      r_left_hold    <= w_left_hold_next;
      r_left_sample  <= w_left_sample_next;
      r_right_sample <= w_right_sample_next;
      r_sample_valid <= w_sample_valid_next;
      r_frame_error  <= w_frame_error_next;
      r_locked       <= (w_state_next != S_HUNT);
    end
  end

  // Next-state, word capture and pulse generation
  always_comb begin
    w_state_next        = r_state;
    w_cnt_next          = r_cnt;
    w_shift_next        = r_shift;
    w_left_hold_next    = r_left_hold;
    w_left_sample_next  = r_left_sample;
    w_right_sample_next = r_right_sample;
    w_sample_valid_next = 1'b0;
    w_frame_error_next  = 1'b0;

    case (r_state)
      S_HUNT: begin
        if (w_fall) begin
          w_state_next = S_LEFT;
          w_cnt_next   = {CW{1'b0}};
        end else begin
          w_state_next = S_HUNT;
        end
      end

      S_LEFT: begin
        if (w_bit_taken) begin
          w_shift_next = w_shift_in;
          w_cnt_next   = r_cnt + CW'(1);
        end else begin
          w_cnt_next = r_cnt;
        end
        if (w_word_done) begin
          w_left_hold_next = w_shift_in;
        end else begin
          w_left_hold_next = r_left_hold;
        end
        if (w_rise) begin
          w_cnt_next = {CW{1'b0}};
          if (w_word_full) begin
            w_state_next = S_RIGHT;
          end else begin
            // A 1-bit word right after an error must not stretch the pulse to two cycles.
            w_state_next       = S_HUNT;
            w_frame_error_next = ~r_frame_error;
          end
        end else begin
          w_state_next = S_LEFT;
        end
      end

      S_RIGHT: begin
        if (w_bit_taken) begin
          w_shift_next = w_shift_in;
          w_cnt_next   = r_cnt + CW'(1);
        end else begin
          w_cnt_next = r_cnt;
        end
        if (w_word_done) begin
          w_left_sample_next  = r_left_hold;
          w_right_sample_next = w_shift_in;
          w_sample_valid_next = 1'b1;
        end else begin
          w_sample_valid_next = 1'b0;
        end
        if (w_fall) begin
          w_cnt_next   = {CW{1'b0}};
          w_state_next = S_LEFT;
          if (w_word_full) begin
            w_frame_error_next = 1'b0;
          end else begin
            w_frame_error_next = ~r_frame_error;
          end
        end else begin
          w_state_next = S_RIGHT;
        end
      end

      default: begin
        w_state_next = S_HUNT;
        w_cnt_next   = {CW{1'b0}};
      end
    endcase
  end

  assign i2s.o_left_sample  = r_left_sample;
  assign i2s.o_right_sample = r_right_sample;
  assign i2s.o_sample_valid = r_sample_valid;
  assign i2s.o_frame_error  = r_frame_error;
  assign i2s.o_locked       = r_locked;
endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives I2S frames on the falling edge, observes on the falling edge.
module tb_i2s_receiver;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  i2s_receiver_if #(.SAMPLE_WIDTH(W)) bus ();

  i2s_receiver #(.SAMPLE_WIDTH(W)) dut (
    .i_serial_clk(clk),
    .i_reset     (rst),
    .i2s         (bus)
  );

  always #5 clk = ~clk;

  int   n_checks       = 0;
  int   n_pass         = 0;
  int   n_valid        = 0;
  int   n_err          = 0;
  int   n_viol         = 0;
  int   n_period_bad   = 0;
  int   n_unlock       = 0;
  int   cyc            = 0;
  int   last_valid_cyc = -1;
  int   exp_period     = 0;
  logic prev_valid     = 1'b0;
  logic prev_err       = 1'b0;
  logic lock_chk       = 1'b0;
  int   base_v, base_e, base_p;

  // Pulse monitor: counts pulses, spacing between sample_valid, and pulse-rule violations
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_valid_cyc = -1;
      prev_valid     = 1'b0;
      prev_err       = 1'b0;
    end else begin
      if (bus.o_sample_valid && bus.o_frame_error) n_viol++;
      if (bus.o_sample_valid && prev_valid) n_viol++;
      if (bus.o_frame_error && prev_err) n_viol++;
      if (bus.o_sample_valid) begin
        n_valid++;
        if (exp_period != 0 && last_valid_cyc >= 0 && (cyc - last_valid_cyc) != exp_period)
          n_period_bad++;
        last_valid_cyc = cyc;
      end
      if (bus.o_frame_error) n_err++;
      if (lock_chk && !bus.o_locked) n_unlock++;
      prev_valid = bus.o_sample_valid;
      prev_err   = bus.o_frame_error;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(input logic ws, input logic b);
    @(negedge clk);
    bus.i_word_select  = ws;
    bus.i_sound_bit_in = b;
  endtask

  // val is left-justified (MSB at bit 31); ws flips on the word's last bit (one-bit I2S delay)
  task automatic send_word(input logic [31:0] val, input int len, input logic is_left);
    for (int k = 0; k < len; k++) begin
      logic last;
      logic b;
      last = (k == len - 1);
      b    = (k < 32) ? val[31-k] : 1'b0;
      bit_out(is_left ? last : ~last, b);
    end
  endtask

  task automatic send_frame(input logic [31:0] lv, input int ll, input logic [31:0] rv, input int rl);
    send_word(lv, ll, 1'b1);
    send_word(rv, rl, 1'b0);
  endtask

  task automatic idle(input int n, input logic ws);
    repeat (n) bit_out(ws, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst                = 1'b1;
    bus.i_word_select  = 1'b0;
    bus.i_sound_bit_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic take_bases();
    base_v = n_valid;
    base_e = n_err;
    base_p = n_period_bad;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] lv;
    logic [31:0] exp;
    bus.i_word_select  = 1'b0;
    bus.i_sound_bit_in = 1'b0;

    // Reset state
    #12;
    check_eq("rst_left",   32'(bus.o_left_sample),  32'h0);
    check_eq("rst_right",  32'(bus.o_right_sample), 32'h0);
    check_eq("rst_valid",  32'(bus.o_sample_valid), 32'h0);
    check_eq("rst_err",    32'(bus.o_frame_error),  32'h0);
    check_eq("rst_locked", 32'(bus.o_locked),       32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 34-clock frames, left alternating 0x7FFF/0xFFFF every 5 frames, right 0
    exp_period = 34;
    take_bases();
    for (int f = 0; f < 10; f++) begin
      lv = (((f / 5) % 2) == 1) ? 32'hFFFF_0000 : 32'h7FFF_0000;
      send_frame(lv, 17, 32'h0, 17);
      #1;
      exp = (f == 0) ? 32'h0 : {16'h0, lv[31:16]};
      check_eq($sformatf("pat_left_f%0d", f), 32'(bus.o_left_sample), exp);
    end
    idle(3, 1'b0);
    #1;
    check_eq("pat_valid_cnt", 32'(n_valid - base_v),      32'd9);
    check_eq("pat_err_cnt",   32'(n_err - base_e),        32'd0);
    check_eq("pat_right",     32'(bus.o_right_sample),    32'h0);
    check_eq("pat_period",    32'(n_period_bad - base_p), 32'd0);

    // Back-to-back 32-clock frames: completion coincides with the falling transition
    do_reset();
    exp_period = 32;
    take_bases();
    send_frame(32'hA5C3_0000, 16, 32'h3C5A_0000, 16);
    send_frame(32'hA5C3_0000, 16, 32'h3C5A_0000, 16);
    lock_chk = 1'b1;
    repeat (4) send_frame(32'hA5C3_0000, 16, 32'h3C5A_0000, 16);
    idle(3, 1'b0);
    #1;
    lock_chk = 1'b0;
    check_eq("b2b_left",      32'(bus.o_left_sample),     32'hA5C3);
    check_eq("b2b_right",     32'(bus.o_right_sample),    32'h3C5A);
    check_eq("b2b_valid_cnt", 32'(n_valid - base_v),      32'd5);
    check_eq("b2b_err_cnt",   32'(n_err - base_e),        32'd0);
    check_eq("b2b_period",    32'(n_period_bad - base_p), 32'd0);
    check_eq("b2b_unlock",    32'(n_unlock),              32'd0);

    // Left word cut at 10 bits by a rising transition
    do_reset();
    exp_period = 0;
    take_bases();
    send_frame(32'h0, 16, 32'h0, 16);
    send_frame(32'h1111_0000, 16, 32'h2222_0000, 16);
    send_word(32'hFFC0_0000, 10, 1'b1);
    send_word(32'h0, 16, 1'b0);
    #1;
    check_eq("cut_locked",    32'(bus.o_locked),       32'h0);
    check_eq("cut_err_cnt",   32'(n_err - base_e),     32'd1);
    check_eq("cut_valid_cnt", 32'(n_valid - base_v),   32'd1);
    check_eq("cut_left_hold", 32'(bus.o_left_sample),  32'h1111);
    check_eq("cut_right_hold",32'(bus.o_right_sample), 32'h2222);
    send_frame(32'h1357_0000, 16, 32'h2468_0000, 16);
    idle(3, 1'b0);
    #1;
    check_eq("cut_next_left",  32'(bus.o_left_sample),  32'h1357);
    check_eq("cut_next_right", 32'(bus.o_right_sample), 32'h2468);
    check_eq("cut_valid_cnt2", 32'(n_valid - base_v),   32'd2);
    check_eq("cut_err_cnt2",   32'(n_err - base_e),     32'd1);
    check_eq("cut_relocked",   32'(bus.o_locked),       32'h1);

    // 24-bit words: only the top 16 bits are kept
    do_reset();
    exp_period = 48;
    take_bases();
    repeat (3) send_frame(32'h1234_5600, 24, 32'hABCD_EF00, 24);
    idle(3, 1'b0);
    #1;
    check_eq("w24_left",      32'(bus.o_left_sample),     32'h1234);
    check_eq("w24_right",     32'(bus.o_right_sample),    32'hABCD);
    check_eq("w24_err_cnt",   32'(n_err - base_e),        32'd0);
    check_eq("w24_valid_cnt", 32'(n_valid - base_v),      32'd2);
    check_eq("w24_period",    32'(n_period_bad - base_p), 32'd0);

    // Reset asserted during a right word
    do_reset();
    exp_period = 0;
    take_bases();
    send_frame(32'h0, 16, 32'h0, 16);
    send_frame(32'hBEEF_0000, 16, 32'hCAFE_0000, 16);
    send_word(32'h0F0F_0000, 16, 1'b1);
    repeat (8) bit_out(1'b1, 1'b1);
    #1;
    check_eq("mrst_pre_left",   32'(bus.o_left_sample), 32'hBEEF);
    check_eq("mrst_pre_locked", 32'(bus.o_locked),      32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mrst_left",   32'(bus.o_left_sample),  32'h0);
    check_eq("mrst_right",  32'(bus.o_right_sample), 32'h0);
    check_eq("mrst_locked", 32'(bus.o_locked),       32'h0);
    check_eq("mrst_valid",  32'(bus.o_sample_valid), 32'h0);
    do_reset();
    check_eq("mrst_valid_cnt", 32'(n_valid - base_v), 32'd1);
    send_frame(32'h0, 16, 32'h0, 16);
    send_frame(32'h5AA5_0000, 16, 32'h00FF_0000, 16);
    idle(3, 1'b0);
    #1;
    check_eq("mrst_relock_left",  32'(bus.o_left_sample),  32'h5AA5);
    check_eq("mrst_relock_right", 32'(bus.o_right_sample), 32'h00FF);
    check_eq("mrst_valid_cnt2",   32'(n_valid - base_v),   32'd2);
    check_eq("mrst_locked2",      32'(bus.o_locked),       32'h1);

    // word_select held high with toggling data: never locks
    do_reset();
    take_bases();
    for (int k = 0; k < 100; k++) begin
      bit_out(1'b1, ((k % 2) == 1));
    end
    @(negedge clk);
    #1;
    check_eq("ws1_locked",    32'(bus.o_locked),     32'h0);
    check_eq("ws1_valid_cnt", 32'(n_valid - base_v), 32'd0);
    check_eq("ws1_err_cnt",   32'(n_err - base_e),   32'd0);

    check_eq("pulse_rules", 32'(n_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 16: number of sample bits captured per channel.
REQ-002 serial_clk  input  1  bit clock; the block's only clock; all sampling occurs on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 word_select  input  1  I2S channel select; 0 = left, 1 = right.
REQ-005 sound_bit_in  input  1  I2S serial data, MSB first.
REQ-006 left_sample  output  SAMPLE_WIDTH  last completed left word, held between updates.
REQ-007 right_sample  output  SAMPLE_WIDTH  last completed right word, held between updates.
REQ-008 sample_valid  output  1  one-cycle pulse; left_sample/right_sample hold a new frame.
REQ-009 frame_error  output  1  one-cycle pulse; short word detected.
REQ-010 locked  output  1  high while aligned to frames (state LEFT or RIGHT).

Function
REQ-011 Transition cycle SHALL be defined as the edge n at which sampled word_select differs from the value sampled at edge n-1; falling transition = new value 0.
REQ-012 A channel word SHALL consist of the bits sampled from edge n+1 through the next transition edge p inclusive (one-bit I2S delay; the bit on the transition edge belongs to the ending word).
REQ-013 The first SAMPLE_WIDTH bits of a word SHALL be shifted in MSB first; later bits SHALL be ignored; the per-channel bit counter SHALL saturate at SAMPLE_WIDTH.
REQ-014 States: HUNT, LEFT, RIGHT; states SHALL change only on transition edges.
REQ-015 HUNT: data is ignored; a falling transition -> LEFT; a rising transition is ignored.
REQ-016 LEFT: when the SAMPLE_WIDTH-th bit is sampled, the word SHALL be stored in an internal left holding register; a rising transition -> RIGHT.
REQ-017 RIGHT: on the edge that samples the SAMPLE_WIDTH-th bit, left_sample <= left holding, right_sample <= the word, and sample_valid SHALL be high for the following cycle; a falling transition -> LEFT.
REQ-018 Short word: a transition edge ending a LEFT or RIGHT word with fewer than SAMPLE_WIDTH bits (counting that edge's bit) SHALL pulse frame_error, discard the partial frame, and leave outputs unchanged; next state LEFT if the transition is falling, else HUNT.
REQ-019 Simultaneous: if the right word's SAMPLE_WIDTH-th bit is sampled on a falling transition edge, the block SHALL both complete the frame (sample_valid pulse) and enter LEFT with a zeroed bit counter.
REQ-020 sample_valid and frame_error SHALL never be high in the same cycle and SHALL never be high for two consecutive cycles.
REQ-021 locked SHALL be 1 exactly when the state is LEFT or RIGHT.

Reset
REQ-022 While reset is high: state HUNT, bit counters 0, previous-word_select register 0, shift and holding registers 0, and all outputs 0, without waiting for a clock edge.
REQ-023 After reset deassertion, word_select held at 0 SHALL NOT count as a transition; the first falling transition is required for lock.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; no sample_valid SHALL occur for it.

Verification
REQ-025 Team test pattern: 34-clock frames, left 0x7FFF/0xFFFF alternating every 5 frames, right 0. Required: first frame after reset is dropped (no transition), then one sample_valid per 34 clocks with left_sample following the pattern, right_sample = 0x0000, frame_error never set.
REQ-026 Back-to-back 32-clock frames, left 0xA5C3, right 0x3C5A. Required: sample_valid every 32 cycles on the falling-transition edge (REQ-019), outputs 0xA5C3/0x3C5A, locked stays 1.
REQ-027 Left word cut at 10 bits by a rising transition. Required: one frame_error pulse, no sample_valid, outputs keep previous values, locked = 0 until the next falling transition, next full frame captured correctly.
REQ-028 24-bit words, left 0x123456, right 0xABCDEF. Required: left_sample = 0x1234, right_sample = 0xABCD, no frame_error.
REQ-029 Reset pulsed during a right word. Required: all outputs 0 immediately, no sample_valid for that frame, relock on the next falling transition.
REQ-030 word_select held at 1 after reset while data toggles for 100 clocks. Required: locked = 0, sample_valid and frame_error never asserted.
